// File: rtl/adder_pipe_if.sv
// Operand/result bundle for the pipelined add/subtract unit.
// Latency: none (signal container only).
// Backpressure: in_ready and out_ready carry stalls in both directions.
//
// Ports:
//   in_valid/in_ready     operand handshake (producer -> unit)
//   a, b, sub             operands and operation select (0 add, 1 subtract)
//   out_valid/out_ready   result handshake (unit -> consumer)
//   sum, ovf              WIDTH+1-bit result (MSB carry/borrow) and signed overflow
interface adder_pipe_if #(
  parameter int WIDTH = 18
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   sum;
  logic             ovf;

  // master: the side that issues operands and consumes results
  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, sum, ovf
  );

  // slave: the arithmetic unit
  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, sum, ovf
  );
endinterface

// File: rtl/adder_pipe.sv
// Pipelined WIDTH-bit add/subtract; carry chain split into STAGES registered chunks.
// Latency: STAGES cycles from accept to out_valid, one operation per cycle.
// Backpressure: out_valid && !out_ready freezes every stage and drops in_ready.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high; clears all valid bits and the result
//   bus    adder_pipe_if.slave: in_valid/in_ready/a/b/sub in,
//          out_valid/out_ready/sum/ovf out
module adder_pipe #(
  parameter int WIDTH  = 18,
  parameter int STAGES = 3
) (
  input  logic        clk,
  input  logic        reset,
  adder_pipe_if.slave bus
);

  // Chunk width; trailing chunks past WIDTH are empty and just forward state.
  localparam int CW   = (WIDTH + STAGES - 1) / STAGES;
  localparam int LAST = STAGES - 1;

  // Per-stage registered state.
  logic             v_q   [STAGES];
  logic             c_q   [STAGES];
  logic             sub_q [STAGES];
  logic             sa_q  [STAGES];
  logic             sb_q  [STAGES];
  logic [WIDTH-1:0] s_q   [STAGES];
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];

  // Per-stage next state, produced by the chunk adders below.
  logic             v_d   [STAGES];
  logic             c_d   [STAGES];
  logic             sub_d [STAGES];
  logic             sa_d  [STAGES];
  logic             sb_d  [STAGES];
  logic [WIDTH-1:0] s_d   [STAGES];
  logic [WIDTH-1:0] a_d   [STAGES];
  logic [WIDTH-1:0] b_d   [STAGES];

  logic stall;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * CW;
    localparam int HI = ((k + 1) * CW < WIDTH) ? (k + 1) * CW - 1 : WIDTH - 1;

    logic             v_i, c_i, sub_i, sa_i, sb_i;
    logic [WIDTH-1:0] s_i, a_i, b_i;
    logic [WIDTH-1:0] s_o;
    logic             c_o;

    if (k == 0) begin : g_in
      // Subtraction is a + ~b + 1: invert b here and inject the 1 as carry-in.
      assign v_i   = bus.in_valid;
      assign sub_i = bus.sub;
      assign a_i   = bus.a;
      assign b_i   = bus.sub ? ~bus.b : bus.b;
      assign c_i   = bus.sub;
      assign s_i   = '0;
      assign sa_i  = bus.a[WIDTH-1];
      assign sb_i  = b_i[WIDTH-1];
    end else begin : g_chain
      assign v_i   = v_q[k-1];
      assign sub_i = sub_q[k-1];
      assign a_i   = a_q[k-1];
      assign b_i   = b_q[k-1];
      assign c_i   = c_q[k-1];
      assign s_i   = s_q[k-1];
      assign sa_i  = sa_q[k-1];
      assign sb_i  = sb_q[k-1];
    end

    if (LO < WIDTH) begin : g_add
      logic [HI-LO+1:0] part;

      assign part = {1'b0, a_i[HI:LO]} + {1'b0, b_i[HI:LO]}
                  + {{(HI - LO + 1){1'b0}}, c_i};
      assign c_o  = part[HI-LO+1];

      // Splice this chunk's sum into the partial result; other bits pass.
      always_comb begin
        s_o        = s_i;
        s_o[HI:LO] = part[HI-LO:0];
      end
    end else begin : g_empty
      assign c_o = c_i;
      assign s_o = s_i;
    end

    assign v_d[k]   = v_i;
    assign c_d[k]   = c_o;
    assign sub_d[k] = sub_i;
    assign sa_d[k]  = sa_i;
    assign sb_d[k]  = sb_i;
    assign s_d[k]   = s_o;
    assign a_d[k]   = a_i;
    assign b_d[k]   = b_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k]   <= 1'b0;
        c_q[k]   <= 1'b0;
        sub_q[k] <= 1'b0;
        sa_q[k]  <= 1'b0;
        sb_q[k]  <= 1'b0;
        s_q[k]   <= '0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
      end
    end else if (!stall) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k]   <= v_d[k];
        c_q[k]   <= c_d[k];
        sub_q[k] <= sub_d[k];
        sa_q[k]  <= sa_d[k];
        sb_q[k]  <= sb_d[k];
        s_q[k]   <= s_d[k];
        a_q[k]   <= a_d[k];
        b_q[k]   <= b_d[k];
      end
    end
  end

  // The whole pipe moves in lockstep, so only a held output can stall it.
  assign stall         = v_q[LAST] && !bus.out_ready;
  assign bus.in_ready  = reset || !stall;
  assign bus.out_valid = v_q[LAST];
  // For subtraction the final carry is the inverted borrow.
  assign bus.sum       = {c_q[LAST] ^ sub_q[LAST], s_q[LAST]};
  assign bus.ovf       = (sa_q[LAST] == sb_q[LAST]) && (s_q[LAST][WIDTH-1] != sa_q[LAST]);

endmodule

// File: doc/adder_pipe.md
# adder_pipe

Parametrised, pipelined add/subtract unit that replaces the fixed 18-bit ripple adder in the arithmetic path. It splits the WIDTH-bit carry chain into STAGES registered chunks, so the design closes timing at wide widths. It accepts one operation per cycle under a valid/ready handshake with output backpressure. Each result carries the carry-out (or borrow) and a signed-overflow flag.

## Interface
- WIDTH, default 18: operand width in bits; legal range 1 to 64.
- STAGES, default 3: number of pipeline stages, which is also the latency; legal range 1 to WIDTH.
- clk  input  1  the single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  the operand set is valid this cycle.
- in_ready  output  1  the unit accepts the operand set this cycle.
- a  input  WIDTH  first operand.
- b  input  WIDTH  second operand.
- sub  input  1  0 selects a+b; 1 selects a-b.
- out_valid  output  1  the result is valid.
- out_ready  input  1  the consumer takes the result this cycle.
- sum  output  WIDTH+1  result; bit WIDTH is the carry-out (add) or the borrow (sub).
- ovf  output  1  two's-complement signed overflow of the WIDTH-bit result.

## Operation
- Chunking:
  - Chunk width is CW = ceil(WIDTH/STAGES). Chunk k covers bits [k·CW, min((k+1)·CW, WIDTH)−1].
  - Chunks beyond WIDTH are empty. An empty chunk only passes its carry and data through.
- Stage k adds chunk k of a and of b_eff, plus the carry registered by stage k−1. Stage 0 takes cin as its carry.
  - For add: b_eff = b and cin = 0.
  - For sub: b_eff = ~b and cin = 1.
- Each stage registers its partial sum, its carry, the still-unprocessed upper operand chunks, sub, and the sign bits a[WIDTH−1] and b_eff[WIDTH−1].
- Final carry c:
  - Add: sum[WIDTH] = c. The result is exact, so sum = a+b in WIDTH+1 bits.
  - Sub: sum[WIDTH] = ~c, which is the borrow and is 1 iff a < b unsigned. sum[WIDTH−1:0] = (a−b) mod 2^WIDTH.
- ovf = 1 iff a[WIDTH−1] == b_eff[WIDTH−1] and sum[WIDTH−1] differs from them.
- Handshake and stall:
  - A transfer occurs on a cycle with in_valid && in_ready. The output is consumed on a cycle with out_valid && out_ready.
  - stall = out_valid && !out_ready. While stalled, every pipeline register holds its value.
  - in_ready = !stall, driven combinationally from out_valid and out_ready. There are no bubble-squeezing requirements.
- A per-stage valid bit travels with the data. When not stalled, a stage whose predecessor is empty becomes invalid.
- Results emerge strictly in input order. No transaction is lost or duplicated.
- sum and ovf are don't-care when out_valid = 0. The bench must not check them then.

## Timing
- Latency: an operand accepted at edge n produces out_valid = 1 with its result at edge n+STAGES, assuming no stall.
- Throughput: one result per cycle while out_ready stays high.
- Stall: the output and all internal stages freeze for every cycle that out_ready is low with out_valid high. A held result stays stable until consumed.
- Reset:
  - All valid bits, out_valid, sum, and ovf clear to 0 on the first rising edge with reset high, including mid-operation.
  - In-flight operations are discarded. in_ready is 1 while reset is high.
  - The first accept is possible on the first edge after reset deasserts.
- Simultaneous events:
  - The output is consumed and a new operand accepted in the same cycle: both take effect, and the pipeline advances one stage.
  - reset is asserted at the same time as a handshake: reset wins and nothing is accepted.
- STAGES = 1: a single registered full-width adder with latency 1.
- STAGES = WIDTH: one bit per stage.

## Test plan
Test 1 uses WIDTH = 18, STAGES = 1. All other tests use WIDTH = 18, STAGES = 3.
- Add at STAGES = 1: a = 0x00003, b = 0x00004, sub = 0 -> sum = 0x00007, ovf = 0, one cycle after accept.
- Carry ripple across all chunks: a = 0x3FFFF, b = 0x00001, sub = 0.
  - Required: sum = 0x40000, ovf = 0, out_valid exactly 3 cycles after accept.
- Subtract and signed overflow, issued back-to-back:
  - a = 5, b = 7, sub = 1 -> sum = 0x7FFFE (borrow 1, low bits 0x3FFFE), ovf = 0.
  - a = 0x1FFFF, b = 1, sub = 0 -> sum = 0x20000, ovf = 1.
  - a = 0x20000, b = 1, sub = 1 -> sum = 0x1FFFF, ovf = 1.
- Backpressure: stream 6 operations of i+i for i = 1..6. Hold out_ready low for 2 cycles after the first result.
  - Required: results 2, 4, 6, 8, 10, 12 in order with none lost.
  - in_ready is low exactly during the stall cycles, and the held sum stays stable.
- Reset mid-operation: accept 2 operations, then assert reset for 1 cycle.
  - Required: out_valid = 0 and sum = 0 after that edge, and no stale result appears afterwards.
  - A new 1+1 accepted after reset yields 2 at 3 cycles.
- Random: 10,000 random a, b, and sub values with random out_ready, compared against a reference model of a+b or a−b (WIDTH+1 bits) and the ovf rule.
  - Run at WIDTH = 18 and 32.
  - STAGES ∈ {1, 3, 7}, plus STAGES = WIDTH.
